// File: rtl/mem_map_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the data width, the default I/O page base address and the register
// offsets inside that page, the controller state type, the read-source
// selector type, and a small address-decode helper.
package mem_map_pkg;

    localparam int unsigned DATA_W = 16;

    // First address of the I/O page; everything at or above it bypasses RAM.
    localparam logic [15:0] IO_BASE = 16'hFFF0;

    // Offsets of the I/O registers relative to the page base.
    localparam logic [15:0] IO_LED = 16'h0000;
    localparam logic [15:0] IO_SW  = 16'h0001;
    localparam logic [15:0] IO_CNT = 16'h0002;

    // Controller states: INIT self-clears the RAM, RUN services requests.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Which registered source drives the read-data output this cycle.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_IO   = 2'd2
    } rd_src_t;

    // True when the address lies in the I/O page.
    function automatic logic is_io_addr(input logic [15:0] addr, input logic [15:0] base);
        return (addr >= base);
    endfunction

endpackage

// File: rtl/dm_sync_ram.sv
// Single-port word-addressed synchronous RAM with a registered read port.
// A write and a read of the same word in one cycle return the new data
// (write-first). Contents are not reset; the owner clears them explicitly.
// Ports:
//   clk      in   rising-edge clock
//   wr_en    in   1 = write wr_data to addr this edge
//   addr     in   word index
//   wr_data  in   store data
//   rd_data  out  registered read data, one cycle after addr
module dm_sync_ram #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned DATA_W    = 16
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic [DATA_W-1:0]    rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write-first storage array with a registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[addr] <= wr_data;
            rd_data     <= wr_data;
        end else begin
            rd_data     <= mem_r[addr];
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Responder for the MemoryAccess stage's data-memory interface.
// After reset the RAM is cleared one word per cycle (INIT); once every word is
// zero the block enters RUN and services one load or store per cycle with a
// fixed one-cycle read latency. A small I/O page at the top of the address
// space holds the LED register, the switch input and a free-running counter.
// Ports:
//   clk                      in   rising-edge clock
//   reset                    in   synchronous, active-high
//   address_to_memory        in   word address from MA
//   data_to_memory           in   store data from MA
//   data_to_memory_write_en  in   1 = store, 0 = load/idle
//   data_from_memory         out  read data, valid the cycle after the address
//   mem_ready                out  0 while the RAM is being cleared
//   io_switches              in   external switch levels (read at IO_BASE+1)
//   io_leds                  out  LED register (R/W at IO_BASE+0)
module data_memory_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter logic [15:0] IO_BASE   = mem_map_pkg::IO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address_to_memory,
    input  logic [15:0] data_to_memory,
    input  logic        data_to_memory_write_en,
    output logic [15:0] data_from_memory,
    output logic        mem_ready,
    input  logic [15:0] io_switches,
    output logic [15:0] io_leds
);

    import mem_map_pkg::*;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_BITS-1:0]  clr_idx_r;
    logic                  clr_last_s;
    logic [15:0]           cycle_cnt_r;
    rd_src_t               rd_src_r;
    logic [15:0]           io_rd_r;
    logic [15:0]           io_rd_s;
    logic [15:0]           io_off_s;
    logic                  is_io_s;
    logic                  led_wr_s;
    logic                  cnt_wr_s;
    logic                  ram_we_s;
    logic [ADDR_BITS-1:0]  ram_addr_s;
    logic [15:0]           ram_wdata_s;
    logic [15:0]           ram_rd_s;

    assign is_io_s    = is_io_addr(address_to_memory, IO_BASE);
    assign io_off_s   = address_to_memory - IO_BASE;
    assign clr_last_s = (clr_idx_r == {ADDR_BITS{1'b1}});

    // Stores only reach I/O registers in RUN and only at their exact offset.
    assign led_wr_s = (state_r == RUN) && data_to_memory_write_en && is_io_s && (io_off_s == IO_LED);
    assign cnt_wr_s = (state_r == RUN) && data_to_memory_write_en && is_io_s && (io_off_s == IO_CNT);

    // Next-state logic: INIT runs until the last word is cleared, RUN is terminal.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            INIT: begin
                if (clr_last_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            RUN:     state_nxt_s = RUN;
            default: state_nxt_s = INIT;
        endcase
    end

    // RAM port steering: the clear sweep owns the port in INIT, MA owns it in RUN.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = address_to_memory[ADDR_BITS-1:0];
        ram_wdata_s = data_to_memory;
        if (reset) begin
            ram_we_s = 1'b0;
        end else if (state_r == INIT) begin
            ram_we_s    = 1'b1;
            ram_addr_s  = clr_idx_r;
            ram_wdata_s = 16'h0000;
        end else if (data_to_memory_write_en && !is_io_s) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
    end

    // I/O read mux; the LED read is write-first to match RAM behaviour.
    always_comb begin
        io_rd_s = 16'h0000;
        case (io_off_s)
            IO_LED: begin
                if (data_to_memory_write_en) begin
                    io_rd_s = data_to_memory;
                end else begin
                    io_rd_s = io_leds;
                end
            end
            IO_SW:   io_rd_s = io_switches;
            IO_CNT:  io_rd_s = cycle_cnt_r;
            default: io_rd_s = 16'h0000;
        endcase
    end

    // Controller state, clear index, I/O registers and read-source pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= INIT;
            clr_idx_r   <= {ADDR_BITS{1'b0}};
            mem_ready   <= 1'b0;
            io_leds     <= 16'h0000;
            cycle_cnt_r <= 16'h0000;
            rd_src_r    <= SRC_ZERO;
            io_rd_r     <= 16'h0000;
        end else begin
            state_r   <= state_nxt_s;
            mem_ready <= (state_nxt_s == RUN);
            if (state_r == INIT) begin
                clr_idx_r <= clr_idx_r + 1'b1;
                rd_src_r  <= SRC_ZERO;
                io_rd_r   <= 16'h0000;
            end else begin
                clr_idx_r <= clr_idx_r;
                if (is_io_s) begin
                    rd_src_r <= SRC_IO;
                end else begin
                    rd_src_r <= SRC_RAM;
                end
                io_rd_r <= io_rd_s;
                if (led_wr_s) begin
                    io_leds <= data_to_memory;
                end else begin
                    io_leds <= io_leds;
                end
                // An explicit store to the counter overrides that cycle's increment.
                if (cnt_wr_s) begin
                    cycle_cnt_r <= data_to_memory;
                end else begin
                    cycle_cnt_r <= cycle_cnt_r + 16'h0001;
                end
            end
        end
    end

    dm_sync_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we_s),
        .addr    (ram_addr_s),
        .wr_data (ram_wdata_s),
        .rd_data (ram_rd_s)
    );

    // Output select from registered sources; zero while clearing or after reset.
    always_comb begin
        data_from_memory = 16'h0000;
        case (rd_src_r)
            SRC_RAM:  data_from_memory = ram_rd_s;
            SRC_IO:   data_from_memory = io_rd_r;
            default:  data_from_memory = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

    logic        clk;
    logic        reset;
    logic [15:0] address_to_memory;
    logic [15:0] data_to_memory;
    logic        data_to_memory_write_en;
    logic [15:0] data_from_memory;
    logic        mem_ready;
    logic [15:0] io_switches;
    logic [15:0] io_leds;

    int tests_run;
    int tests_failed;

    data_memory_responder #(
        .ADDR_BITS (4),
        .IO_BASE   (16'hFFF0)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .address_to_memory       (address_to_memory),
        .data_to_memory          (data_to_memory),
        .data_to_memory_write_en (data_to_memory_write_en),
        .data_from_memory        (data_from_memory),
        .mem_ready               (mem_ready),
        .io_switches             (io_switches),
        .io_leds                 (io_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request at a falling edge; returns at the next falling edge,
    // by which time the rising edge in between has consumed the request.
    task automatic do_op(input logic [15:0] a, input logic [15:0] d, input logic w);
        address_to_memory       = a;
        data_to_memory          = d;
        data_to_memory_write_en = w;
        @(negedge clk);
        data_to_memory_write_en = 1'b0;
    endtask

    // Counts falling edges with mem_ready low, bounded.
    task automatic wait_ready(output int low_cycles, output logic timed_out);
        low_cycles = 0;
        timed_out  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (mem_ready === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            low_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int   low_cycles;
        logic timed_out;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (mem_ready !== 1'b0 || data_from_memory !== 16'h0000 || io_leds !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b data=%h leds=%h required 0/0000/0000",
                     mem_ready, data_from_memory, io_leds);
        end
        reset = 1'b0;
        wait_ready(low_cycles, timed_out);
        tests_run++;
        if (timed_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL init_timeout: mem_ready still %b after 40 cycles, required 1", mem_ready);
        end
        tests_run++;
        if (low_cycles !== 16) begin
            tests_failed++;
            $display("FAIL init_length: mem_ready low %0d cycles, required 16", low_cycles);
        end
        for (int i = 0; i < 16; i++) begin
            do_op(16'(i), 16'h0000, 1'b0);
            tests_run++;
            if (data_from_memory !== 16'h0000) begin
                tests_failed++;
                $display("FAIL cleared_word[%0d]: got %h required 0000", i, data_from_memory);
            end
        end
    endtask

    task automatic test_store_load;
        do_op(16'h0005, 16'hBEEF, 1'b1);
        do_op(16'h0005, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL load_0005: got %h required BEEF", data_from_memory);
        end
        do_op(16'h0015, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL alias_0015: got %h required BEEF", data_from_memory);
        end
        // Last RAM address below the I/O page aliases to index F.
        do_op(16'hFFEF, 16'hCAFE, 1'b1);
        do_op(16'h000F, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'hCAFE) begin
            tests_failed++;
            $display("FAIL ram_top_ffef: got %h required CAFE", data_from_memory);
        end
    endtask

    task automatic test_write_first;
        do_op(16'h0003, 16'h1234, 1'b1);
        tests_run++;
        if (data_from_memory !== 16'h1234) begin
            tests_failed++;
            $display("FAIL write_first_0003: got %h required 1234", data_from_memory);
        end
        do_op(16'h0003, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'h1234) begin
            tests_failed++;
            $display("FAIL reload_0003: got %h required 1234", data_from_memory);
        end
    endtask

    task automatic test_io;
        do_op(16'hFFF0, 16'h00A5, 1'b1);
        tests_run++;
        if (io_leds !== 16'h00A5 || data_from_memory !== 16'h00A5) begin
            tests_failed++;
            $display("FAIL led_store: leds=%h data=%h required 00A5/00A5", io_leds, data_from_memory);
        end
        do_op(16'hFFF0, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'h00A5) begin
            tests_failed++;
            $display("FAIL led_load: got %h required 00A5", data_from_memory);
        end
        io_switches = 16'h5A5A;
        do_op(16'hFFF1, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL sw_load: got %h required 5A5A", data_from_memory);
        end
        do_op(16'hFFF1, 16'h1111, 1'b1);
        tests_run++;
        if (data_from_memory !== 16'h5A5A || io_leds !== 16'h00A5) begin
            tests_failed++;
            $display("FAIL sw_store_ignored: data=%h leds=%h required 5A5A/00A5", data_from_memory, io_leds);
        end
        do_op(16'hFFF7, 16'hFFFF, 1'b1);
        do_op(16'hFFF7, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'h0000 || io_leds !== 16'h00A5) begin
            tests_failed++;
            $display("FAIL unmapped_fff7: data=%h leds=%h required 0000/00A5", data_from_memory, io_leds);
        end
        // A store into the I/O page must not reach the aliased RAM word.
        do_op(16'hFFF5, 16'hDEAD, 1'b1);
        do_op(16'h0005, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL io_no_ram_write: got %h required BEEF", data_from_memory);
        end
    endtask

    task automatic test_counter;
        do_op(16'hFFF2, 16'hFFFE, 1'b1);
        do_op(16'hFFF2, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL cnt_first: got %h required FFFE", data_from_memory);
        end
        do_op(16'hFFF2, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL cnt_second: got %h required FFFF", data_from_memory);
        end
        do_op(16'hFFF2, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'h0000) begin
            tests_failed++;
            $display("FAIL cnt_wrap: got %h required 0000", data_from_memory);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals [3];
        vals[0] = 16'h00A1;
        vals[1] = 16'h00B2;
        vals[2] = 16'h00C3;
        for (int i = 0; i < 3; i++) begin
            do_op(16'(8 + i), vals[i], 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            do_op(16'(8 + i), 16'h0000, 1'b0);
            tests_run++;
            if (data_from_memory !== vals[i]) begin
                tests_failed++;
                $display("FAIL b2b_load[%0d]: got %h required %h", i, data_from_memory, vals[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int   low_cycles;
        logic timed_out;
        do_op(16'h0002, 16'h7777, 1'b1);
        do_op(16'hFFF0, 16'h00FF, 1'b1);
        tests_run++;
        if (io_leds !== 16'h00FF) begin
            tests_failed++;
            $display("FAIL pre_reset_leds: got %h required 00FF", io_leds);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (io_leds !== 16'h0000 || mem_ready !== 1'b0 || data_from_memory !== 16'h0000) begin
            tests_failed++;
            $display("FAIL mid_reset_state: leds=%h ready=%b data=%h required 0000/0/0000",
                     io_leds, mem_ready, data_from_memory);
        end
        reset = 1'b0;
        do_op(16'hFFF0, 16'h1234, 1'b1);
        do_op(16'hFFF2, 16'h4321, 1'b1);
        do_op(16'h0002, 16'h5555, 1'b1);
        tests_run++;
        if (io_leds !== 16'h0000 || data_from_memory !== 16'h0000 || mem_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL init_ignores_stores: leds=%h data=%h ready=%b required 0000/0000/0",
                     io_leds, data_from_memory, mem_ready);
        end
        wait_ready(low_cycles, timed_out);
        tests_run++;
        if (timed_out !== 1'b0 || low_cycles !== 13) begin
            tests_failed++;
            $display("FAIL reinit_length: timeout=%b remaining low %0d, required 0/13", timed_out, low_cycles);
        end
        // First RUN cycle: counter was held at zero throughout INIT.
        do_op(16'hFFF2, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'h0000) begin
            tests_failed++;
            $display("FAIL cnt_after_init: got %h required 0000", data_from_memory);
        end
        do_op(16'h0002, 16'h0000, 1'b0);
        tests_run++;
        if (data_from_memory !== 16'h0000) begin
            tests_failed++;
            $display("FAIL recleared_0002: got %h required 0000", data_from_memory);
        end
    endtask

    initial begin
        tests_run               = 0;
        tests_failed            = 0;
        reset                   = 1'b1;
        address_to_memory       = 16'h0000;
        data_to_memory          = 16'h0000;
        data_to_memory_write_en = 1'b0;
        io_switches             = 16'h0000;
        @(negedge clk);
        test_reset();
        test_store_load();
        test_write_first();
        test_io();
        test_counter();
        test_back_to_back();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
